// File: rtl/fpnew_pkg.sv
// Shared floating-point format definitions and helpers for the fpnew div/sqrt slice.
// Mantissa widths per format drive operand sizing and iteration counts.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned FP_FORMAT_BITS = $clog2(NUM_FP_FORMATS);

  typedef enum logic [FP_FORMAT_BITS-1:0] {
    FP32    = 'd0,
    FP64    = 'd1,
    FP16    = 'd2,
    FP8     = 'd3,
    FP16ALT = 'd4
  } fp_format_e;

  typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned max_man_bits(fmt_logic_t cfg);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
      if (cfg[i] && (man_bits(fp_format_e'(FP_FORMAT_BITS'(i))) > res)) begin
        res = man_bits(fp_format_e'(FP_FORMAT_BITS'(i)));
      end
    end
    return res;
  endfunction

  // Integer bit, mantissa bits, guard and round: one quotient/root bit per iteration.
  function automatic int unsigned divsqrt_iters(fp_format_e fmt);
    return man_bits(fmt) + 3;
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_iter_core.sv
// Iterative radix-2 restoring mantissa divide / square-root engine.
// Produces a left-aligned quotient or root plus a sticky bit for the rounding stage.
module fpnew_divsqrt_iter_core
  import fpnew_pkg::*;
#(
  parameter fmt_logic_t FpFmtConfig = '1,
  localparam int unsigned MANT_WIDTH = max_man_bits(FpFmtConfig) + 1,
  localparam int unsigned RES_WIDTH  = MANT_WIDTH + 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  div_start_i,
  input  logic                  sqrt_start_i,
  input  logic                  kill_i,
  input  fp_format_e            fp_fmt_i,
  input  logic [MANT_WIDTH-1:0] op_a_i,
  input  logic [MANT_WIDTH-1:0] op_b_i,
  input  logic [MANT_WIDTH:0]   radicand_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [RES_WIDTH-1:0]  result_o,
  output logic                  sticky_o
);

  // Sqrt remainder can grow to twice the partial root plus two shifted-in bits.
  localparam int unsigned REM_WIDTH = RES_WIDTH + 3;
  localparam int unsigned CNT_WIDTH = $clog2(RES_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                state_q;
  logic                  is_sqrt_q;
  logic [CNT_WIDTH-1:0]  cnt_q, iters_q, iters_sel, shamt;
  logic [REM_WIDTH-1:0]  rem_q, rem_d, rem_sh, trial, diff;
  logic [RES_WIDTH-1:0]  quot_q, quot_d, result_q;
  logic [MANT_WIDTH-1:0] divisor_q;
  logic [MANT_WIDTH:0]   rad_q, rad_d;
  logic                  q_bit, sticky_q, start, last_iter;

  assign start     = div_start_i | sqrt_start_i;
  assign iters_sel = FpFmtConfig[fp_fmt_i] ? CNT_WIDTH'(divsqrt_iters(fp_fmt_i))
                                           : CNT_WIDTH'(RES_WIDTH);
  assign last_iter = (cnt_q == iters_q - 1'b1);
  assign shamt     = CNT_WIDTH'(RES_WIDTH) - iters_q;

  // One restoring step: divide compares against the divisor, sqrt against (Q<<2)|1.
  always_comb begin
    rem_sh = rem_q;
    trial  = {{(REM_WIDTH-MANT_WIDTH){1'b0}}, divisor_q};
    rad_d  = rad_q;
    if (is_sqrt_q) begin
      rem_sh = {rem_q[REM_WIDTH-3:0], rad_q[MANT_WIDTH -: 2]};
      trial  = {1'b0, quot_q, 2'b01};
      rad_d  = {rad_q[MANT_WIDTH-2:0], 2'b00};
    end
    q_bit  = (rem_sh >= trial);
    diff   = q_bit ? (rem_sh - trial) : rem_sh;
    rem_d  = is_sqrt_q ? diff : {diff[REM_WIDTH-2:0], 1'b0};
    quot_d = {quot_q[RES_WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      is_sqrt_q <= 1'b0;
      cnt_q     <= '0;
      iters_q   <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      rad_q     <= '0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
    end else if (kill_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= BUSY;
            is_sqrt_q <= ~div_start_i;
            iters_q   <= iters_sel;
            cnt_q     <= '0;
            quot_q    <= '0;
            divisor_q <= op_b_i;
            rad_q     <= radicand_i;
            rem_q     <= div_start_i ? {{(REM_WIDTH-MANT_WIDTH){1'b0}}, op_a_i} : '0;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          rad_q  <= rad_d;
          cnt_q  <= cnt_q + 1'b1;
          // Result is captured only here so it stays stable across later starts and kills.
          if (last_iter) begin
            state_q  <= DONE;
            result_q <= quot_d << shamt;
            sticky_q <= |rem_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q != BUSY);
  assign done_o   = (state_q == DONE);
  assign busy_o   = (state_q == BUSY);
  assign result_o = result_q;
  assign sticky_o = sticky_q;

endmodule

// File: tb/tb_fpnew_divsqrt_iter_core.sv
// Self-checking bench for fpnew_divsqrt_iter_core: directed vectors, handshake corners,
// and random operands checked against an arithmetic (long division / integer sqrt) model.
module tb_fpnew_divsqrt_iter_core;
  import fpnew_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_start = 1'b0;
  logic        sqrt_start = 1'b0;
  logic        kill = 1'b0;
  fp_format_e  fp_fmt = FP32;
  logic [52:0] op_a = '0;
  logic [52:0] op_b = '0;
  logic [53:0] radicand = '0;
  logic        ready, done, busy, sticky;
  logic [54:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       is_div;
    logic       is_sqrt;
    fp_format_e fmt;
    logic [52:0] a;
    logic [52:0] b;
    logic [53:0] rad;
    logic [54:0] exp_res;
    logic        exp_sticky;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  fpnew_divsqrt_iter_core dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .div_start_i (div_start),
    .sqrt_start_i(sqrt_start),
    .kill_i      (kill),
    .fp_fmt_i    (fp_fmt),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .radicand_i  (radicand),
    .ready_o     (ready),
    .done_o      (done),
    .busy_o      (busy),
    .result_o    (result),
    .sticky_o    (sticky)
  );

  always #5 clk = ~clk;

  function automatic int iters_of(fp_format_e f);
    case (f)
      FP32:    return 26;
      FP64:    return 55;
      FP16:    return 13;
      FP16ALT: return 10;
      default: return 5;
    endcase
  endfunction

  // Returns {sticky, result}: quotient = floor(a*2^(n-1)/b), root = isqrt of the top 2n radicand bits.
  function automatic logic [55:0] ref_model(logic do_sqrt, fp_format_e f, logic [52:0] a,
                                            logic [52:0] b, logic [53:0] rad);
    int n;
    logic [127:0] num, q, x, t;
    logic st;
    n = iters_of(f);
    q = '0;
    if (!do_sqrt) begin
      num = 128'(a) << (n - 1);
      q   = num / 128'(b);
      st  = ((num % 128'(b)) != 0);
    end else begin
      x = (2 * n >= 54) ? (128'(rad) << (2 * n - 54)) : (128'(rad) >> (54 - 2 * n));
      for (int k = n - 1; k >= 0; k--) begin
        t = q | (128'(1) << k);
        if (t * t <= x) q = t;
      end
      st = (q * q != x);
    end
    return {st, 55'(q << (55 - n))};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(string name, logic [127:0] actual, logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drives a start for one cycle from a negedge; returns in cycle 1 of the operation.
  task automatic apply_stimulus(logic d, logic s, fp_format_e f, logic [52:0] a, logic [52:0] b,
                                logic [53:0] rad);
    div_start  = d;
    sqrt_start = s;
    fp_fmt     = f;
    op_a       = a;
    op_b       = b;
    radicand   = rad;
    tick();
    div_start  = 1'b0;
    sqrt_start = 1'b0;
  endtask

  task automatic wait_done(int first, int limit, output int lat, output logic busy_ok);
    lat = first;
    busy_ok = 1'b1;
    while (!done && lat < limit) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic run_vector(vec_t v, output logic [54:0] res_seen);
    int lat;
    logic busy_ok;
    apply_stimulus(v.is_div, v.is_sqrt, v.fmt, v.a, v.b, v.rad);
    wait_done(1, 200, lat, busy_ok);
    check_output({v.name, "_latency"}, lat, v.exp_lat);
    check_output({v.name, "_busy"}, busy_ok, 1'b1);
    check_output({v.name, "_result"}, result, v.exp_res);
    check_output({v.name, "_sticky"}, sticky, v.exp_sticky);
    res_seen = result;
    tick();
    check_output({v.name, "_after_done"}, {done, ready, busy}, 3'b010);
  endtask

  initial begin
    logic [52:0] one, one_half, one_5, one_25, one_75;
    logic [53:0] rad_225, rad_2;
    logic [55:0] m;
    logic [54:0] res_seen, prior;
    logic [63:0] r;
    logic [22:0] sqrt2_top;
    int lat, n, mb;
    logic busy_ok, held_ok, done_seen, do_sqrt;
    fp_format_e f;

    one      = 53'(1) << 52;
    one_half = 53'(1) << 51;
    one_5    = one | one_half;
    one_25   = one | (53'(1) << 50);
    one_75   = one_5 | (53'(1) << 50);
    rad_225  = 54'(4'b1001) << 50;
    rad_2    = 54'(1) << 53;
    sqrt2_top = 23'b10110101000001001111001;

    // Reset state
    tick();
    check_output("rst_ready", ready, 1'b1);
    check_output("rst_done", done, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_result", result, 55'd0);
    check_output("rst_sticky", sticky, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    m = ref_model(1'b1, FP64, '0, '0, rad_2);
    vecs[0] = '{"fp32_div_1p5_1p0", 1'b1, 1'b0, FP32, one_5, one, '0, 55'(2'b11) << 53, 1'b0, 27};
    vecs[1] = '{"fp32_div_1p0_1p5", 1'b1, 1'b0, FP32, one, one_5, '0,
                55'(26'h1555555) << 29, 1'b1, 27};
    vecs[2] = '{"fp64_sqrt_2p25", 1'b0, 1'b1, FP64, '0, '0, rad_225, 55'(2'b11) << 53, 1'b0, 56};
    vecs[3] = '{"fp64_sqrt_2p0", 1'b0, 1'b1, FP64, '0, '0, rad_2, m[54:0], m[55], 56};
    vecs[4] = '{"fp16_div_1p75_1p25", 1'b1, 1'b0, FP16, one_75, one_25, '0,
                55'(13'b1011001100110) << 42, 1'b1, 14};
    vecs[5] = '{"fp8_both_starts", 1'b1, 1'b1, FP8, one, one_5, rad_225,
                55'(5'b01010) << 50, 1'b1, 6};
    vecs[6] = '{"fp16alt_sqrt_2p25", 1'b0, 1'b1, FP16ALT, '0, '0, rad_225,
                55'(2'b11) << 53, 1'b0, 11};

    for (int i = 0; i < 7; i++) begin
      run_vector(vecs[i], res_seen);
      if (i == 3) check_output("sqrt2_top_bits", res_seen[54 -: 23], sqrt2_top);
    end

    // Start while busy is ignored
    apply_stimulus(1'b1, 1'b0, FP32, one_5, one, '0);
    tick();
    tick();
    div_start = 1'b1; sqrt_start = 1'b1; op_a = one; op_b = one_5; fp_fmt = FP8;
    tick();
    div_start = 1'b0; sqrt_start = 1'b0;
    wait_done(4, 200, lat, busy_ok);
    check_output("busy_start_latency", lat, 27);
    check_output("busy_start_result", result, 55'(2'b11) << 53);
    check_output("busy_start_sticky", sticky, 1'b0);
    tick();
    prior = result;

    // Kill mid-operation, with a simultaneous start that must be ignored
    apply_stimulus(1'b1, 1'b0, FP16, one_5, one_5, '0);
    done_seen = 1'b0;
    for (int c = 1; c < 5; c++) begin
      if (done) done_seen = 1'b1;
      tick();
    end
    kill = 1'b1; div_start = 1'b1; op_a = one_75; op_b = one_25;
    tick();
    kill = 1'b0; div_start = 1'b0;
    check_output("kill_no_done", done_seen | done, 1'b0);
    check_output("kill_ready", {ready, busy}, 2'b10);
    check_output("kill_result_held", result, prior);
    apply_stimulus(1'b1, 1'b0, FP16, one, one, '0);
    wait_done(1, 200, lat, busy_ok);
    check_output("post_kill_latency", lat, 14);
    check_output("post_kill_result", result, 55'(1) << 54);
    check_output("post_kill_sticky", sticky, 1'b0);

    // Back-to-back: new start in the DONE cycle of the previous op
    tick();
    apply_stimulus(1'b1, 1'b0, FP32, one, one_5, '0);
    wait_done(1, 200, lat, busy_ok);
    prior = result;
    check_output("b2b_first_result", prior, 55'(26'h1555555) << 29);
    apply_stimulus(1'b0, 1'b1, FP16ALT, '0, '0, rad_225);
    held_ok = 1'b1;
    lat = 1;
    while (!done && lat < 100) begin
      if (result !== prior) held_ok = 1'b0;
      tick();
      lat++;
    end
    check_output("b2b_latency", lat, 11);
    check_output("b2b_result_held", held_ok, 1'b1);
    check_output("b2b_result", result, 55'(2'b11) << 53);
    check_output("b2b_sticky", sticky, 1'b0);
    tick();

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      f = fp_format_e'(3'($urandom_range(0, 4)));
      do_sqrt = 1'($urandom_range(0, 1));
      n = iters_of(f);
      mb = n - 3;
      r = {$urandom, $urandom};
      op_a = one | (53'(r[51:0]) & ~((53'(1) << (52 - mb)) - 53'(1)));
      r = {$urandom, $urandom};
      op_b = one | (53'(r[51:0]) & ~((53'(1) << (52 - mb)) - 53'(1)));
      r = {$urandom, $urandom};
      radicand = r[53:0] & ~((54'(1) << (52 - mb)) - 54'(1));
      if (radicand[53:52] == 2'b00) radicand[52] = 1'b1;
      m = ref_model(do_sqrt, f, op_a, op_b, radicand);
      apply_stimulus(~do_sqrt, do_sqrt, f, op_a, op_b, radicand);
      wait_done(1, 200, lat, busy_ok);
      check_output(do_sqrt ? "rand_sqrt_latency" : "rand_div_latency", lat, n + 1);
      check_output(do_sqrt ? "rand_sqrt_result" : "rand_div_result", result, m[54:0]);
      check_output(do_sqrt ? "rand_sqrt_sticky" : "rand_div_sticky", sticky, m[55]);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
